// File: rtl/tge_tx_packetizer_if.sv
// Stream-in and core-TX signal bundle for the 10GbE TX packetizer.
// The master side is the packetizer; the slave side is the sample source plus core.
interface tge_tx_packetizer_if;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        tx_valid;
    logic        tx_end_of_frame;
    logic [63:0] tx_data;
    logic [31:0] tx_dest_ip;
    logic [15:0] tx_dest_port;
    logic        tx_afull;
    logic        tx_overflow;

    modport master (
        input  in_valid, in_data, tx_afull, tx_overflow,
        output in_ready, tx_valid, tx_end_of_frame, tx_data, tx_dest_ip, tx_dest_port
    );

    modport slave (
        output in_valid, in_data, tx_afull, tx_overflow,
        input  in_ready, tx_valid, tx_end_of_frame, tx_data, tx_dest_ip, tx_dest_port
    );
endinterface

// File: rtl/tge_tx_packetizer.sv
// Packs a 64-bit sample stream into UDP frames for the 10GbE core user TX port,
// with optional {seq, len} header, programmable inter-packet gap and event counters.
//
// state   | meaning
// IDLE    | waiting for enable && !tx_afull, latches frame fields
// HEADER  | emits the {seq, len} header word
// PAYLOAD | forwards accepted input words until len reached
// GAP     | counts the latched gap down before the next frame
module tge_tx_packetizer #(
    parameter int LEN_W     = 9,
    parameter bit HEADER_EN = 1'b1,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [LEN_W-1:0]     payload_len,
    input  logic [15:0]          pkt_gap,
    input  logic [31:0]          dest_ip,
    input  logic [15:0]          dest_port,
    tge_tx_packetizer_if.master  bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     pkt_count,
    output logic [CNT_W-1:0]     drop_count,
    output logic [CNT_W-1:0]     overflow_count
);

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_GAP} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   word_cnt;
    logic [15:0]        gap_q;
    logic [15:0]        gap_cnt;
    logic [31:0]        ip_q;
    logic [15:0]        port_q;
    logic [47:0]        seq_q;
    logic               start;
    logic               emit_hdr;
    logic               accept;
    logic               last_word;

    assign start     = (state_q == S_IDLE) && enable && !bus.tx_afull;
    assign emit_hdr  = (state_q == S_HEADER);
    assign accept    = bus.in_valid && bus.in_ready;
    assign last_word = accept && (word_cnt == len_q - LEN_W'(1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = HEADER_EN ? S_HEADER : S_PAYLOAD;
            S_HEADER:  state_d = S_PAYLOAD;
            S_PAYLOAD: if (last_word) state_d = (gap_q != 16'd0) ? S_GAP : S_IDLE;
            S_GAP:     if (gap_cnt == 16'd1) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (state_q == S_PAYLOAD);
        busy         = (state_q != S_IDLE);
    end

    // Destination fields stay stable from frame start through the header and EOF.
    assign bus.tx_dest_ip   = ip_q;
    assign bus.tx_dest_port = port_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q               <= '0;
            word_cnt            <= '0;
            gap_q               <= '0;
            gap_cnt             <= '0;
            ip_q                <= '0;
            port_q              <= '0;
            seq_q               <= '0;
            bus.tx_valid        <= 1'b0;
            bus.tx_end_of_frame <= 1'b0;
            bus.tx_data         <= '0;
            pkt_count           <= '0;
            drop_count          <= '0;
            overflow_count      <= '0;
        end else begin
            if (start) begin
                ip_q     <= dest_ip;
                port_q   <= dest_port;
                gap_q    <= pkt_gap;
                len_q    <= (payload_len == '0) ? LEN_W'(1) : payload_len;
                word_cnt <= '0;
            end

            bus.tx_valid        <= emit_hdr || accept;
            bus.tx_end_of_frame <= last_word;
            if (emit_hdr)    bus.tx_data <= {seq_q, 16'(len_q)};
            else if (accept) bus.tx_data <= bus.in_data;

            if (accept) word_cnt <= word_cnt + LEN_W'(1);

            // Gap counter loads at EOF so GAP lasts exactly gap_q cycles.
            if (last_word) begin
                seq_q   <= seq_q + 48'd1;
                gap_cnt <= gap_q;
                if (pkt_count != '1) pkt_count <= pkt_count + CNT_W'(1);
            end else if (state_q == S_GAP) begin
                gap_cnt <= gap_cnt - 16'd1;
            end

            if (bus.in_valid && !bus.in_ready && drop_count != '1)
                drop_count <= drop_count + CNT_W'(1);
            if (bus.tx_overflow && overflow_count != '1)
                overflow_count <= overflow_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/tge_tx_packetizer.md
Name: tge_tx_packetizer

Overview:
- Application-side transmitter for the 10GbE core's user TX interface (tx_valid / tx_end_of_frame / tx_data / tx_dest_ip / tx_dest_port, tx_afull / tx_overflow).
- Collects a 64-bit sample stream into UDP payload frames of programmable length.
- Optionally prepends a sequence/length header word and enforces a programmable inter-packet gap.
- Runs in the core's application clock domain and keeps event counters for software.

Parameters:
LEN_W, 9, width of payload_len in 64-bit words (max payload 2^LEN_W-1 words).
HEADER_EN, 1, 1 = prepend header word {seq[47:0], len[15:0]} to every frame; 0 = payload only.
CNT_W, 32, width of pkt_count, drop_count and overflow_count.

Ports:
clk  in  1  application clock, same clock as the core's clk.
rst  in  1  synchronous active-high reset.
enable  in  1  allow new frames to start.
payload_len  in  LEN_W  payload words per frame, sampled at frame start.
pkt_gap  in  16  idle cycles after each frame, sampled at frame start.
dest_ip  in  32  destination IP, sampled at frame start.
dest_port  in  16  destination UDP port, sampled at frame start.
in_valid  in  1  input sample valid.
in_data  in  64  input sample.
in_ready  out  1  input word accepted when in_valid && in_ready.
tx_valid  out  1  to core tx_valid.
tx_end_of_frame  out  1  to core tx_end_of_frame.
tx_data  out  64  to core tx_data.
tx_dest_ip  out  32  to core tx_dest_ip.
tx_dest_port  out  16  to core tx_dest_port.
tx_afull  in  1  from core, TX buffer almost full.
tx_overflow  in  1  from core, TX buffer overflowed.
busy  out  1  state != IDLE.
pkt_count  out  CNT_W  frames completed.
drop_count  out  CNT_W  input words offered while in_ready=0.
overflow_count  out  CNT_W  cycles with tx_overflow=1.

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous and active-high.
- On rst all of the following clear to 0: outputs, counters, the sequence number, latched fields and the gap counter. State goes to IDLE.
- Reset mid-frame abandons the frame with no end_of_frame; rst must be driven together with the core's rst.
- All tx_* outputs are registered:
  - A word accepted in cycle N appears on tx_* in cycle N+1 with tx_valid=1.
  - tx_valid is 0 in every cycle with no word.
  - tx_end_of_frame is only ever 1 together with tx_valid.
- FSM states: IDLE, HEADER, PAYLOAD, GAP.
- IDLE:
  - in_ready=0.
  - If enable && !tx_afull: latch dest_ip, dest_port and pkt_gap; latch len = max(payload_len, 1); clear the word counter.
  - Then go to HEADER if HEADER_EN, else PAYLOAD.
  - tx_afull is checked only here; a started frame always completes.
- HEADER:
  - in_ready=0.
  - Emit one word {seq, len zero-extended to 16} with end_of_frame=0, then go to PAYLOAD.
- PAYLOAD:
  - in_ready=1.
  - Each accepted word is emitted and increments the word counter; cycles without in_valid emit nothing (gaps are allowed).
  - The accepted word at which the count reaches len is emitted with tx_end_of_frame=1.
  - In that same cycle: seq increments (48-bit, wraps to 0); pkt_count increments.
  - Next state is GAP if the latched gap is non-zero, else IDLE.
- GAP:
  - in_ready=0.
  - Counts the latched gap down; returns to IDLE after exactly gap cycles in GAP.
- enable deasserted mid-frame: the current frame finishes normally; no new frame starts.
- Changes to payload_len, pkt_gap, dest_ip or dest_port mid-frame have no effect until the next frame start.
- tx_dest_ip and tx_dest_port hold the latched values for the whole frame, including the header word.
- drop_count increments each cycle with in_valid && !in_ready.
- overflow_count increments each cycle with tx_overflow=1.
- All counters saturate at all-ones and never wrap.
- Frame-start latency: enable rising in IDLE → header word on tx_* 2 cycles later (IDLE decision, HEADER emit, registered output).
- Minimum frame-to-frame spacing with gap=0: one IDLE cycle (plus one HEADER cycle if HEADER_EN=1).

Test Plan:
- HEADER_EN=1, len=4, gap=0, in_valid held high, dest 0x0A000001:4000:
  - Frame 1 is 5 tx_valid words: header 0x0000_0000_0000_0004, then 4 data words, EOF on the 5th.
  - Frame 2 header is 0x0000_0000_0001_0004.
  - pkt_count=2 after frame 2.
- tx_afull=1 held in IDLE with enable=1:
  - No tx_valid, in_ready=0.
  - 10 offered words give drop_count=10.
  - Releasing tx_afull starts a frame on the next cycle.
- tx_afull asserted mid-PAYLOAD with len=8:
  - All 8 words are still emitted, EOF on word 8.
  - The next frame is blocked until tx_afull=0.
- in_valid toggling 1/0 with len=3, HEADER_EN=0:
  - Exactly 3 tx_valid pulses, gaps mirror the input gaps, EOF only on the 3rd.
  - Data matches the input order.
- gap=5, payload_len=0:
  - Each frame is header + 1 word (len clamped to 1).
  - Exactly 5 GAP cycles plus 1 IDLE cycle between the EOF and the next header.
- rst asserted mid-PAYLOAD (word 2 of 4):
  - Next cycle all outputs and counters are 0 and seq=0.
  - The next frame header shows seq 0.
  - tx_overflow held for 3 cycles gives overflow_count=3.
